// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode encodings and channel packing helper
package counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;

   // LSB of channel ch inside a [i*n_bits +: n_bits] packed vector
   function automatic int ch_lsb(input int ch, input int n_bits);
      return ch * n_bits;
   endfunction

endpackage

// File: rtl/mod_counter_if.sv
// rtl/mod_counter_if.sv - control and status bundle for the multi-channel counter
interface mod_counter_if #(
   parameter int N_BITS = 4,
   parameter int N_CH   = 2
);
   logic [N_CH-1:0]        en;
   logic [N_CH-1:0]        up;
   logic [N_CH-1:0]        sat;
   logic [N_CH-1:0]        load;
   logic [N_CH*N_BITS-1:0] load_val;
   logic [N_CH*N_BITS-1:0] max_val;
   logic [N_CH*N_BITS-1:0] count;
   logic [N_CH-1:0]        tc;
   logic [N_CH-1:0]        at_bound;

   modport master (
      output en, up, sat, load, load_val, max_val,
      input  count, tc, at_bound
   );

   modport slave (
      input  en, up, sat, load, load_val, max_val,
      output count, tc, at_bound
   );
endinterface

// File: rtl/mod_counter_ch.sv
// rtl/mod_counter_ch.sv - one counter channel: count register, boundary, carry, tc
module mod_counter_ch
   import counter_pkg::*;
#(
   parameter int N_BITS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              up,
   input  logic              sat,
   input  logic              load,
   input  logic [N_BITS-1:0] load_val,
   input  logic [N_BITS-1:0] max_val,
   output logic [N_BITS-1:0] count,
   output logic              tc,
   output logic              carry,
   output logic              at_bound
);
   logic [N_BITS-1:0] count_nxt;

   // >= so that a loaded value above max_val still wraps or saturates on the next up-step
   assign at_bound = (up == DIR_UP) ? (count >= max_val) : (count == '0);
   assign carry    = step && at_bound && !load && !rst;

   always_comb begin
      count_nxt = count;
      if (load) begin
         count_nxt = load_val;
      end else if (step) begin
         if (at_bound) begin
            if (sat != MODE_SAT) begin
               count_nxt = (up == DIR_UP) ? '0 : max_val;
            end
         end else begin
            count_nxt = (up == DIR_UP) ? count + 1'b1 : count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= carry;
      end
   end
endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - N_CH independent or cascaded up/down modulus counters
module mod_counter
   import counter_pkg::*;
#(
   parameter int N_BITS  = 4,
   parameter int N_CH    = 2,
   parameter int CASCADE = 0
) (
   input  logic         clk,
   input  logic         rst,
   mod_counter_if.slave bus
);
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      localparam int LSB = ch_lsb(i, N_BITS);
      logic step;
      logic carry_o;

      // the carry ripples combinationally so a whole chain rolls over on one edge
      if (CASCADE != 0 && i > 0) begin : g_casc
         assign step = bus.en[i] && g_ch[i-1].carry_o;
      end else begin : g_ind
         assign step = bus.en[i];
      end

      mod_counter_ch #(.N_BITS(N_BITS)) u_ch (
         .clk      (clk),
         .rst      (rst),
         .step     (step),
         .up       (bus.up[i]),
         .sat      (bus.sat[i]),
         .load     (bus.load[i]),
         .load_val (bus.load_val[LSB +: N_BITS]),
         .max_val  (bus.max_val[LSB +: N_BITS]),
         .count    (bus.count[LSB +: N_BITS]),
         .tc       (bus.tc[i]),
         .carry    (carry_o),
         .at_bound (bus.at_bound[i])
      );
   end
endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - scoreboard bench for independent and cascaded mod_counter
module tb_mod_counter;
   logic clk = 1'b0;
   logic rst;
   logic [1:0] en, up, sat, load;
   logic [7:0] load_val, max_val;

   always #5 clk = ~clk;

   mod_counter_if #(.N_BITS(4), .N_CH(2)) bi0 ();
   mod_counter_if #(.N_BITS(4), .N_CH(2)) bi1 ();

   assign bi0.en = en;   assign bi0.up = up;   assign bi0.sat = sat;
   assign bi0.load = load; assign bi0.load_val = load_val; assign bi0.max_val = max_val;
   assign bi1.en = en;   assign bi1.up = up;   assign bi1.sat = sat;
   assign bi1.load = load; assign bi1.load_val = load_val; assign bi1.max_val = max_val;

   mod_counter #(.N_BITS(4), .N_CH(2), .CASCADE(0)) u_ind (.clk(clk), .rst(rst), .bus(bi0));
   mod_counter #(.N_BITS(4), .N_CH(2), .CASCADE(1)) u_cas (.clk(clk), .rst(rst), .bus(bi1));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: index [dut][channel], dut 0 independent, dut 1 cascaded
   int m_cnt [2][2];
   bit m_tc  [2][2];
   logic [19:0] sb_q [$];

   function automatic bit m_atb(input int d, input int i);
      int mx;
      mx = int'(max_val[i*4 +: 4]);
      if (up[i]) return m_cnt[d][i] >= mx;
      return m_cnt[d][i] == 0;
   endfunction

   task automatic model_adv();
      for (int d = 0; d < 2; d++) begin
         bit ab [2];
         bit prev_cy;
         prev_cy = 1'b0;
         for (int i = 0; i < 2; i++) ab[i] = m_atb(d, i);
         for (int i = 0; i < 2; i++) begin
            int mx;
            bit stp;
            bit cy;
            mx  = int'(max_val[i*4 +: 4]);
            stp = en[i] && (d == 0 || i == 0 || prev_cy);
            cy  = 1'b0;
            if (rst) begin
               m_cnt[d][i] = 0;
            end else if (load[i]) begin
               m_cnt[d][i] = int'(load_val[i*4 +: 4]);
            end else if (stp) begin
               cy = ab[i];
               if (ab[i]) begin
                  if (!sat[i]) m_cnt[d][i] = up[i] ? 0 : mx;
               end else begin
                  m_cnt[d][i] = up[i] ? (m_cnt[d][i] + 1) % 16 : (m_cnt[d][i] + 15) % 16;
               end
            end
            m_tc[d][i] = cy;
            prev_cy    = cy;
         end
      end
   endtask

   function automatic logic [9:0] pack_exp(input int d);
      return {4'(m_cnt[d][1]), 4'(m_cnt[d][0]), m_tc[d][1], m_tc[d][0]};
   endfunction

   task automatic cyc();
      logic [19:0] exp;
      #1;
      check("at_bound_ind", 32'(bi0.at_bound), 32'({m_atb(0, 1), m_atb(0, 0)}));
      check("at_bound_cas", 32'(bi1.at_bound), 32'({m_atb(1, 1), m_atb(1, 0)}));
      model_adv();
      sb_q.push_back({pack_exp(1), pack_exp(0)});
      @(posedge clk);
      #1;
      exp = sb_q.pop_front();
      check("count_ind", 32'(bi0.count), 32'(exp[9:2]));
      check("tc_ind",    32'(bi0.tc),    32'(exp[1:0]));
      check("count_cas", 32'(bi1.count), 32'(exp[19:12]));
      check("tc_cas",    32'(bi1.tc),    32'(exp[11:10]));
   endtask

   initial begin
      rst = 1'b1; en = '0; up = '0; sat = '0; load = '0;
      load_val = '0; max_val = '0;
      repeat (2) @(posedge clk);
      #1;

      // load then reset with load and enable asserted
      rst = 1'b0; load = 2'b01; load_val = 8'h07;
      cyc();
      check("load7", 32'(bi0.count[3:0]), 32'd7);
      rst = 1'b1; en = 2'b11; load = 2'b11;
      cyc();
      check("rst_count_ind", 32'(bi0.count), 32'd0);
      check("rst_count_cas", 32'(bi1.count), 32'd0);
      check("rst_tc", 32'({bi0.tc, bi1.tc}), 32'd0);
      rst = 1'b0; load = '0;

      // wrap up 0..9,0
      max_val = 8'h99; up = 2'b11; sat = 2'b00; en = 2'b01;
      for (int k = 1; k <= 25; k++) begin
         cyc();
         if (k == 9) begin
            check("wrap_at9", 32'(bi0.count[3:0]), 32'd9);
            check("wrap_tc_lo", 32'(bi0.tc[0]), 32'd0);
         end
         if (k == 10 || k == 20) begin
            check("wrap_to0", 32'(bi0.count[3:0]), 32'd0);
            check("wrap_tc", 32'(bi0.tc[0]), 32'd1);
         end
      end

      // down with saturation from 2
      en = '0; load = 2'b11; load_val = 8'h22;
      cyc();
      load = '0; up = 2'b00; sat = 2'b11; en = 2'b01;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         if (k == 2) check("sat_tc_before", 32'(bi0.tc[0]), 32'd0);
         if (k >= 3) check("sat_tc_held", 32'(bi0.tc[0]), 32'd1);
      end
      check("sat_count", 32'(bi0.count[3:0]), 32'd0);

      // BCD cascade 00 -> 99 -> 00
      rst = 1'b1; en = '0;
      cyc();
      rst = 1'b0; up = 2'b11; sat = 2'b00; max_val = 8'h99; en = 2'b11;
      repeat (99) cyc();
      check("bcd_99", 32'(bi1.count), 32'h99);
      cyc();
      check("bcd_wrap", 32'(bi1.count), 32'h00);
      check("bcd_tc", 32'(bi1.tc), 32'h3);

      // load on ch0 suppresses cascade carry
      repeat (9) cyc();
      load = 2'b01; load_val = 8'h03;
      cyc();
      check("ldcarry_count", 32'(bi1.count), 32'h03);
      check("ldcarry_tc", 32'(bi1.tc), 32'h0);
      load = '0;

      // out-of-range load
      max_val = 8'h55; en = '0; load = 2'b11; load_val = 8'hcc;
      cyc();
      load = '0; up = 2'b11; en = 2'b11;
      cyc();
      check("oor_up", 32'(bi0.count), 32'h00);
      check("oor_tc", 32'(bi0.tc), 32'h3);
      en = '0; load = 2'b11;
      cyc();
      load = '0; up = 2'b00; en = 2'b11;
      cyc();
      check("oor_down", 32'(bi0.count), 32'hbb);

      // random traffic against the model
      for (int k = 0; k < 300; k++) begin
         rst      = ($urandom_range(0, 40) == 0);
         en       = 2'($urandom_range(0, 3));
         up       = 2'($urandom_range(0, 3));
         sat      = 2'($urandom_range(0, 3));
         load     = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
         load_val = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 15) == 0) max_val = 8'($urandom_range(0, 255));
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
